// File: rtl/memory_arbiter.sv
// Single-port RAM arbiter: serialises instruction fetches and data accesses (data first),
// with a sticky access watchdog. Define IFETCH_BUF_EN for a one-entry instruction buffer.
module memory_arbiter #(
  parameter int unsigned WORD_W  = 32,
  parameter int unsigned TIMEOUT = 64
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              imemREN,
  input  logic [WORD_W-1:0] imemaddr,
  input  logic              dmemREN,
  input  logic              dmemWEN,
  input  logic [WORD_W-1:0] dmemaddr,
  input  logic [WORD_W-1:0] dmemstore,
  output logic              ihit,
  output logic [WORD_W-1:0] imemload,
  output logic              dhit,
  output logic [WORD_W-1:0] dmemload,
  output logic              ramREN,
  output logic              ramWEN,
  output logic [WORD_W-1:0] ramaddr,
  output logic [WORD_W-1:0] ramstore,
  input  logic [WORD_W-1:0] ramload,
  input  logic              ram_ready,
  output logic              timeout_err
);

  localparam int unsigned CntW = $clog2(TIMEOUT + 1);
  localparam logic [CntW-1:0] WdLast = CntW'(TIMEOUT - 1);
  localparam logic [CntW-1:0] WdMax  = CntW'(TIMEOUT);

  typedef enum logic [1:0] {StIdle, StDacc, StIacc} state_e;

  state_e            state_q;
  logic              ren_q, wen_q, err_q;
  logic [WORD_W-1:0] addr_q, store_q;
  logic [CntW-1:0]   wd_cnt_q;
  logic              dreq, buf_hit, abort;

  assign dreq  = dmemREN | dmemWEN;
  assign abort = (state_q == StDacc) ? ~dreq : ~imemREN;

`ifdef IFETCH_BUF_EN
  logic              buf_valid_q;
  logic [WORD_W-1:0] buf_tag_q, buf_data_q;

  assign buf_hit = (state_q == StIdle) && imemREN && !dreq && buf_valid_q &&
                   (buf_tag_q == imemaddr);

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      buf_valid_q <= 1'b0;
      buf_tag_q   <= '0;
      buf_data_q  <= '0;
    end else if (state_q == StIacc && ram_ready) begin
      buf_valid_q <= 1'b1;
      buf_tag_q   <= addr_q;
      buf_data_q  <= ramload;
    end else if (state_q == StDacc && ram_ready && wen_q && addr_q == buf_tag_q) begin
      buf_valid_q <= 1'b0;
    end
  end
`else
  assign buf_hit = 1'b0;
`endif

  // Hits and load data are combinational so they land in the ram_ready cycle.
  always_comb begin
    ihit     = ((state_q == StIacc) && ram_ready) || buf_hit;
    dhit     = (state_q == StDacc) && ram_ready;
    imemload = '0;
    dmemload = '0;
    if (state_q == StIacc && ram_ready) begin
      imemload = ramload;
    end
`ifdef IFETCH_BUF_EN
    else if (buf_hit) begin
      imemload = buf_data_q;
    end
`endif
    if (dhit && !wen_q) begin
      dmemload = ramload;
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q  <= StIdle;
      ren_q    <= 1'b0;
      wen_q    <= 1'b0;
      addr_q   <= '0;
      store_q  <= '0;
      wd_cnt_q <= '0;
      err_q    <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          wd_cnt_q <= '0;
          if (dreq) begin
            state_q <= StDacc;
            ren_q   <= dmemREN & ~dmemWEN;
            wen_q   <= dmemWEN;
            addr_q  <= dmemaddr;
            store_q <= dmemstore;
          end else if (imemREN && !buf_hit) begin
            state_q <= StIacc;
            ren_q   <= 1'b1;
            wen_q   <= 1'b0;
            addr_q  <= imemaddr;
            store_q <= '0;
          end
        end
        StDacc, StIacc: begin
          // Watchdog only flags; the access keeps running.
          if (!ram_ready) begin
            if (wd_cnt_q == WdLast) err_q <= 1'b1;
            if (wd_cnt_q != WdMax) wd_cnt_q <= wd_cnt_q + 1'b1;
          end
          if (ram_ready || abort) begin
            state_q  <= StIdle;
            ren_q    <= 1'b0;
            wen_q    <= 1'b0;
            addr_q   <= '0;
            store_q  <= '0;
            wd_cnt_q <= '0;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign ramREN      = ren_q;
  assign ramWEN      = wen_q;
  assign ramaddr     = addr_q;
  assign ramstore    = store_q;
  assign timeout_err = err_q;

endmodule

// File: tb/tb_memory_arbiter.sv
// Randomised and directed bench for memory_arbiter against a transaction-level model.
module tb_memory_arbiter;

  localparam int unsigned W  = 32;
  localparam int unsigned TO = 64;
`ifdef IFETCH_BUF_EN
  localparam bit BufEn = 1'b1;
`else
  localparam bit BufEn = 1'b0;
`endif

  logic         CLK = 1'b0;
  logic         nRST;
  logic         imemREN, dmemREN, dmemWEN, ram_ready;
  logic [W-1:0] imemaddr, dmemaddr, dmemstore, ramload;
  logic         ihit, dhit, ramREN, ramWEN, timeout_err;
  logic [W-1:0] imemload, dmemload, ramaddr, ramstore;

  memory_arbiter #(.WORD_W(W), .TIMEOUT(TO)) dut (
    .CLK(CLK), .nRST(nRST),
    .imemREN(imemREN), .imemaddr(imemaddr),
    .dmemREN(dmemREN), .dmemWEN(dmemWEN), .dmemaddr(dmemaddr), .dmemstore(dmemstore),
    .ihit(ihit), .imemload(imemload), .dhit(dhit), .dmemload(dmemload),
    .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
    .ramload(ramload), .ram_ready(ram_ready), .timeout_err(timeout_err)
  );

  always #5 CLK = ~CLK;

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  // Outstanding-access record plus buffer contents.
  bit           m_busy, m_data, m_ren, m_wen, m_err;
  logic [W-1:0] m_addr, m_store;
  int           m_wait;
  bit           b_valid;
  logic [W-1:0] b_tag, b_data;

  function automatic bit buf_hit_now();
    return BufEn && !m_busy && imemREN && !(dmemREN || dmemWEN) && b_valid &&
           (b_tag == imemaddr);
  endfunction

  task automatic model_reset();
    m_busy = 0; m_err = 0; m_wait = 0; b_valid = 0;
    m_ren = 0; m_wen = 0; m_data = 0; m_addr = '0; m_store = '0;
    b_tag = '0; b_data = '0;
  endtask

  task automatic check_outputs();
    bit           idone, ddone, bh;
    logic [W-1:0] e_iload, e_dload;
    idone   = m_busy && !m_data && ram_ready;
    ddone   = m_busy && m_data && ram_ready;
    bh      = buf_hit_now();
    e_iload = idone ? ramload : (bh ? b_data : '0);
    e_dload = (ddone && !m_wen) ? ramload : '0;
    check("ihit", {31'b0, ihit}, {31'b0, idone || bh});
    check("dhit", {31'b0, dhit}, {31'b0, ddone});
    check("imemload", imemload, e_iload);
    check("dmemload", dmemload, e_dload);
    check("ramREN", {31'b0, ramREN}, {31'b0, m_busy && m_ren});
    check("ramWEN", {31'b0, ramWEN}, {31'b0, m_busy && m_wen});
    check("ramaddr", ramaddr, m_busy ? m_addr : '0);
    check("ramstore", ramstore, (m_busy && m_data) ? m_store : '0);
    check("timeout_err", {31'b0, timeout_err}, {31'b0, m_err});
  endtask

  task automatic model_step();
    bit bh;
    bh = buf_hit_now();
    if (!nRST) begin
      model_reset();
    end else if (!m_busy) begin
      if (dmemREN || dmemWEN) begin
        m_busy = 1; m_data = 1; m_wen = dmemWEN; m_ren = dmemREN && !dmemWEN;
        m_addr = dmemaddr; m_store = dmemstore; m_wait = 0;
      end else if (imemREN && !bh) begin
        m_busy = 1; m_data = 0; m_wen = 0; m_ren = 1;
        m_addr = imemaddr; m_store = '0; m_wait = 0;
      end
    end else if (ram_ready) begin
      if (!m_data) begin
        b_valid = 1; b_tag = m_addr; b_data = ramload;
      end else if (m_wen && m_addr == b_tag) begin
        b_valid = 0;
      end
      m_busy = 0;
    end else begin
      if (m_wait == TO - 1) m_err = 1;
      if (m_wait < TO) m_wait++;
      if (m_data ? !(dmemREN || dmemWEN) : !imemREN) m_busy = 0;
    end
  endtask

  // Called just after a falling edge with inputs already set.
  task automatic cycle();
    #1 check_outputs();
    @(posedge CLK);
    model_step();
    @(negedge CLK);
  endtask

  task automatic set_in(input bit ir, input logic [W-1:0] ia, input bit dr, input bit dw,
                        input logic [W-1:0] da, input logic [W-1:0] ds, input bit rdy);
    imemREN = ir; imemaddr = ia; dmemREN = dr; dmemWEN = dw;
    dmemaddr = da; dmemstore = ds; ram_ready = rdy; ramload = $urandom;
  endtask

  // Request held for waits+1 not-ready cycles, then one ready cycle, then idle.
  task automatic access(input bit ir, input logic [W-1:0] ia, input bit dr, input bit dw,
                        input logic [W-1:0] da, input logic [W-1:0] ds, input int waits);
    for (int i = 0; i <= waits; i++) begin
      set_in(ir, ia, dr, dw, da, ds, 1'b0);
      cycle();
    end
    set_in(ir, ia, dr, dw, da, ds, 1'b1);
    cycle();
    set_in(0, '0, 0, 0, '0, '0, 1'b0);
    cycle();
  endtask

  logic [W-1:0] addr_tbl [5] = '{32'h20, 32'h24, 32'h28, 32'h2c, 32'h80};

  initial begin
    nRST = 1'b0;
    model_reset();
    set_in(0, '0, 0, 0, '0, '0, 1'b0);
    @(negedge CLK);
    cycle();
    nRST = 1'b1;
    cycle();

    access(1, 32'h10, 0, 0, '0, '0, 3);
    access(1, 32'h30, 1, 0, 32'h80, '0, 0);
    set_in(1, 32'h30, 0, 0, '0, '0, 1'b0);
    cycle();
    set_in(1, 32'h30, 0, 0, '0, '0, 1'b1);
    cycle();
    access(0, '0, 1, 1, 32'h84, 32'hDEAD_BEEF, 1);
    set_in(1, 32'h50, 0, 0, '0, '0, 1'b0);
    cycle();
    cycle();
    set_in(0, 32'h50, 0, 0, '0, '0, 1'b0);
    cycle();
    cycle();
    access(1, 32'h20, 0, 0, '0, '0, 1);
    access(1, 32'h20, 0, 0, '0, '0, 1);
    access(0, '0, 0, 1, 32'h20, 32'h1234, 0);
    access(1, 32'h20, 0, 0, '0, '0, 1);

    set_in(0, '0, 0, 0, '0, '0, 1'b0);
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        imemREN = $urandom_range(0, 2) != 0;
        dmemREN = $urandom_range(0, 3) == 0;
        dmemWEN = $urandom_range(0, 4) == 0;
        imemaddr = addr_tbl[$urandom_range(0, 3)];
        dmemaddr = addr_tbl[$urandom_range(0, 4)];
        dmemstore = $urandom;
      end
      ram_ready = $urandom_range(0, 2) == 0;
      ramload = $urandom;
      cycle();
    end

    for (int i = 0; i < 70; i++) begin
      set_in(1, 32'h100, 0, 0, '0, '0, 1'b0);
      cycle();
    end
    set_in(1, 32'h100, 0, 0, '0, '0, 1'b1);
    cycle();
    set_in(0, '0, 0, 0, '0, '0, 1'b0);
    cycle();
    for (int i = 0; i < 4; i++) begin
      set_in(1, 32'h104, 0, 0, '0, '0, 1'b0);
      cycle();
    end
    #2 nRST = 1'b0;
    ramload = 32'hFFFF_FFFF;
    ram_ready = 1'b1;
    #1;
    check("rst_ramREN", {31'b0, ramREN}, '0);
    check("rst_ramaddr", ramaddr, '0);
    check("rst_ihit", {31'b0, ihit}, '0);
    check("rst_imemload", imemload, '0);
    check("rst_timeout_err", {31'b0, timeout_err}, '0);
    model_reset();
    @(negedge CLK);
    set_in(0, '0, 0, 0, '0, '0, 1'b0);
    cycle();
    nRST = 1'b1;
    access(1, 32'h108, 0, 0, '0, '0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
